// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the rate-1/2, K=3 convolutional codec.
package viterbi_pkg;

   localparam logic [2:0] G0      = 3'b111;
   localparam logic [2:0] G1      = 3'b101;
   localparam int         K       = 3;
   localparam int         NSTATES = 4;

   // Code symbol {g0 parity, g1 parity} emitted when bit b leaves state st = {b[n-1], b[n-2]}.
   function automatic logic [1:0] exp_symbol(input logic [1:0] st, input logic b);
      logic [2:0] reg_bits;
      reg_bits = {b, st};
      return {^(reg_bits & G0), ^(reg_bits & G1)};
   endfunction

   // Hamming distance between two 2-bit symbols (0..2).
   function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] diff;
      diff = a ^ b;
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

endpackage

// File: rtl/decoder.sv
// Hard-decision Viterbi decoder, 4-state trellis, register-exchange survivors.
module decoder
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] d_in,
   output logic       d_out
);

   localparam logic [PM_W-1:0] PM_INIT = PM_W'(16);

   logic [PM_W-1:0]     pm       [NSTATES];
   logic [TB_DEPTH-1:0] surv     [NSTATES];
   logic [PM_W-1:0]     acs_raw  [NSTATES];
   logic [PM_W-1:0]     pm_new   [NSTATES];
   logic [TB_DEPTH-1:0] surv_new [NSTATES];
   logic [PM_W-1:0]     min_pm;
   logic [1:0]          best;

   // Predecessors of ns are {ns[0],0} and {ns[0],1}; the branch bit is ns[1].
   for (genvar s = 0; s < NSTATES; s++) begin : g_acs
      localparam logic [1:0] P0 = 2'((s % 2) * 2);
      localparam logic [1:0] P1 = 2'((s % 2) * 2 + 1);
      localparam logic       B  = 1'(s / 2);

      logic [PM_W-1:0] cand0;
      logic [PM_W-1:0] cand1;
      logic            sel;

      assign cand0 = pm[P0] + PM_W'(hamming2(d_in, exp_symbol(P0, B)));
      assign cand1 = pm[P1] + PM_W'(hamming2(d_in, exp_symbol(P1, B)));
      // Strict compare: ties keep the p0 branch.
      assign sel         = (cand1 < cand0);
      assign acs_raw[s]  = sel ? cand1 : cand0;
      assign pm_new[s]   = acs_raw[s] - min_pm;
      assign surv_new[s] = {(sel ? surv[P1][TB_DEPTH-2:0] : surv[P0][TB_DEPTH-2:0]), B};
   end

   // Minimum metric and best state; ties resolve to the lowest state index.
   always_comb begin
      min_pm = acs_raw[0];
      best   = 2'd0;
      for (int i = 1; i < NSTATES; i++) begin
         if (acs_raw[i] < min_pm) begin
            min_pm = acs_raw[i];
            best   = 2'(i);
         end
      end
   end

   // Metrics, survivors and output advance only on enabled edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NSTATES; i++) begin
            pm[i]   <= (i == 0) ? '0 : PM_INIT;
            surv[i] <= '0;
         end
         d_out <= 1'b0;
      end else if (enable) begin
         for (int i = 0; i < NSTATES; i++) begin
            pm[i]   <= pm_new[i];
            surv[i] <= surv_new[i];
         end
         d_out <= surv_new[best][TB_DEPTH-1];
      end
   end

endmodule

// File: rtl/encoder.sv
// Rate-1/2 convolutional encoder, g0 = 7, g1 = 5 (octal); one bit per enabled edge.
module encoder
   import viterbi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_i,
   input  logic       d_in,
   output logic       valid_o,
   output logic [1:0] d_out
);

   logic [1:0] st;

   // Shift register and registered symbol; valid marks the cycle after an enabled edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st      <= 2'b00;
         valid_o <= 1'b0;
         d_out   <= 2'b00;
      end else if (enable_i) begin
         d_out   <= exp_symbol(st, d_in);
         st      <= {d_in, st[1]};
         valid_o <= 1'b1;
      end else begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/conv_viterbi_codec.sv
// Convolutional encoder and Viterbi decoder as two independent halves on one clock.
module conv_viterbi_codec
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enc_enable_i,
   input  logic       enc_d_i,
   output logic       enc_valid_o,
   output logic [1:0] enc_d_o,
   input  logic       dec_enable_i,
   input  logic [1:0] dec_d_i,
   output logic       dec_d_o
);

   encoder u_enc (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enc_enable_i),
      .d_in     (enc_d_i),
      .valid_o  (enc_valid_o),
      .d_out    (enc_d_o)
   );

   decoder #(
      .TB_DEPTH (TB_DEPTH),
      .PM_W     (PM_W)
   ) u_dec (
      .clk    (clk),
      .rst    (rst),
      .enable (dec_enable_i),
      .d_in   (dec_d_i),
      .d_out  (dec_d_o)
   );

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Scoreboard bench for conv_viterbi_codec: impulse, loopback, errors, gaps, reset.
module tb_conv_viterbi_codec;

   localparam int TB_DEPTH = 16;
   localparam int PM_W     = 6;
   localparam int NBITS    = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enc_enable_i = 1'b0;
   logic       enc_d_i = 1'b0;
   logic       enc_valid_o;
   logic [1:0] enc_d_o;
   logic       dec_enable_i = 1'b0;
   logic [1:0] dec_d_i = 2'b00;
   logic       dec_d_o;

   int checks   = 0;
   int failures = 0;
   bit q_exp [$];
   bit bits_rand [NBITS];
   bit bits_zero [NBITS];
   int max_pm;

   conv_viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .enc_enable_i (enc_enable_i),
      .enc_d_i      (enc_d_i),
      .enc_valid_o  (enc_valid_o),
      .enc_d_o      (enc_d_o),
      .dec_enable_i (dec_enable_i),
      .dec_d_i      (dec_d_i),
      .dec_d_o      (dec_d_o)
   );

   always #5 clk = ~clk;

   task automatic clear_scoreboard();
      q_exp.delete();
      for (int i = 0; i < TB_DEPTH - 1; i++) q_exp.push_back(1'b0);
      max_pm = 0;
   endtask

   task automatic do_reset();
      enc_enable_i = 1'b0;
      enc_d_i      = 1'b0;
      dec_enable_i = 1'b0;
      dec_d_i      = 2'b00;
      rst = 1'b0;
      #12;
      @(negedge clk);
      rst = 1'b1;
      clear_scoreboard();
   endtask

   task automatic check_pm_reset(input string name);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (int'(dut.u_dec.pm[i]) !== ((i == 0) ? 0 : 16)) begin
            failures++;
            $display("FAIL %s pm[%0d] got=%0d exp=%0d", name, i, dut.u_dec.pm[i], (i == 0) ? 0 : 16);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++;
      if ({enc_valid_o, enc_d_o, dec_d_o} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0000", {enc_valid_o, enc_d_o, dec_d_o});
      end
      check_pm_reset("reset");
      do_reset();
   endtask

   task automatic test_impulse(input string name);
      bit         ib [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [1:0] es [4] = '{2'b11, 2'b10, 2'b11, 2'b00};
      checks++;
      if (enc_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL %s valid_before got=%b exp=0", name, enc_valid_o);
      end
      for (int i = 0; i < 4; i++) begin
         enc_enable_i = 1'b1;
         enc_d_i      = ib[i];
         @(posedge clk); #1;
         checks++;
         if (enc_d_o !== es[i] || enc_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL %s sym%0d got=%b/%b exp=%b/1", name, i, enc_d_o, enc_valid_o, es[i]);
         end
      end
      enc_enable_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (enc_valid_o !== 1'b0 || enc_d_o !== 2'b00) begin
         failures++;
         $display("FAIL %s after got=%b/%b exp=00/0", name, enc_d_o, enc_valid_o);
      end
   endtask

   // Encoder output is registered one cycle into the decoder by the bench.
   task automatic test_loopback(input string name, input bit use_rand, input int gap_pct,
                                input int err_period);
      int         k = 0;
      int         sym_idx = 0;
      int         cyc = 0;
      bit         b;
      bit         dec_was;
      bit         exp_b;
      bit         gap;
      logic       prev_dec;
      logic [1:0] prev_enc;
      logic [1:0] sym;
      while ((k < NBITS || dec_enable_i) && cyc < NBITS * 4 + 100) begin
         cyc++;
         gap = (gap_pct > 0) && ($urandom_range(99) < gap_pct);
         if (k < NBITS && !gap) begin
            b = use_rand ? bits_rand[k] : bits_zero[k];
            enc_enable_i = 1'b1;
            enc_d_i      = b;
            q_exp.push_back(b);
            k++;
         end else begin
            enc_enable_i = 1'b0;
         end
         prev_enc = enc_d_o;
         prev_dec = dec_d_o;
         dec_was  = dec_enable_i;
         @(posedge clk); #1;
         if (!enc_enable_i) begin
            checks++;
            if (enc_valid_o !== 1'b0 || enc_d_o !== prev_enc) begin
               failures++;
               $display("FAIL %s enc_hold got=%b/%b exp=%b/0", name, enc_d_o, enc_valid_o, prev_enc);
            end
         end
         if (dec_was) begin
            if (q_exp.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL %s scoreboard_empty got=%b exp=none", name, dec_d_o);
            end else begin
               exp_b = q_exp.pop_front();
               checks++;
               if (dec_d_o !== exp_b) begin
                  failures++;
                  $display("FAIL %s dec_bit got=%b exp=%b cyc=%0d", name, dec_d_o, exp_b, cyc);
               end
            end
            for (int i = 0; i < 4; i++)
               if (int'(dut.u_dec.pm[i]) > max_pm) max_pm = int'(dut.u_dec.pm[i]);
         end else begin
            checks++;
            if (dec_d_o !== prev_dec) begin
               failures++;
               $display("FAIL %s dec_hold got=%b exp=%b", name, dec_d_o, prev_dec);
            end
         end
         sym = enc_d_o;
         if (enc_valid_o) begin
            if (err_period > 0 && (sym_idx % err_period) == 3)
               sym[(sym_idx / err_period) % 2] = ~sym[(sym_idx / err_period) % 2];
            sym_idx++;
         end
         dec_d_i      = sym;
         dec_enable_i = enc_valid_o;
      end
      enc_enable_i = 1'b0;
      dec_enable_i = 1'b0;
      checks++;
      if (k != NBITS || dec_enable_i) begin
         failures++;
         $display("FAIL %s timeout got=%0d exp=%0d", name, k, NBITS);
      end
   endtask

   task automatic test_errors();
      test_loopback("errors", 1'b1, 0, 8);
      checks++;
      if (max_pm > 18) begin
         failures++;
         $display("FAIL pm_bound got=%0d exp<=18", max_pm);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 41; i++) begin
         enc_enable_i = 1'b1;
         enc_d_i      = bits_rand[i];
         @(posedge clk); #1;
         dec_d_i      = enc_d_o;
         dec_enable_i = enc_valid_o;
      end
      enc_enable_i = 1'b0;
      dec_enable_i = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({enc_valid_o, enc_d_o, dec_d_o} !== 4'b0000) begin
         failures++;
         $display("FAIL mid_reset_outputs got=%b exp=0000", {enc_valid_o, enc_d_o, dec_d_o});
      end
      check_pm_reset("mid_reset");
      @(negedge clk);
      rst = 1'b1;
      clear_scoreboard();
      test_impulse("mid_impulse");
      check_pm_reset("mid_restart");
      test_loopback("mid_loopback", 1'b1, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < NBITS; i++) begin
         bits_rand[i] = 1'($urandom_range(1));
         bits_zero[i] = 1'b0;
      end
      do_reset();
      test_reset();
      test_impulse("impulse");
      do_reset();
      test_loopback("all_zero", 1'b0, 0, 0);
      do_reset();
      test_loopback("random", 1'b1, 0, 0);
      do_reset();
      test_errors();
      do_reset();
      test_loopback("gaps", 1'b1, 30, 0);
      do_reset();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
